// File: rtl/panda_pkg.sv
// Shared types for the panda core memory subsystem.
// Requester ids used by the RAM arbiter.
package panda_pkg;

  localparam int unsigned RamReqNum = 2;

  typedef enum logic {
    ReqIf,
    ReqLs
  } ram_req_id_e;

endpackage

// File: rtl/panda_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant bit.
// Bit 0 is fetch, bit 1 is load/store.
module panda_rr_arbiter2
  import panda_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [RamReqNum-1:0] req_i,
  output logic [RamReqNum-1:0] gnt_o
);

  ram_req_id_e last_q;
  ram_req_id_e last_d;
  logic [RamReqNum-1:0] req;

  // No grant may leak out while reset is held.
  assign req = req_i & {RamReqNum{rst_ni}};

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    unique case (req)
      2'b11: begin
        if (last_q == ReqIf) gnt_o = 2'b10;
        else                 gnt_o = 2'b01;
      end
      2'b10:   gnt_o = 2'b10;
      2'b01:   gnt_o = 2'b01;
      default: gnt_o = '0;
    endcase
    if (gnt_o[1])      last_d = ReqLs;
    else if (gnt_o[0]) last_d = ReqIf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= ReqIf;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/panda_ram_arbiter.sv
// Shares one single-port RAM between fetch and load/store.
// Responses are routed back to the issuing port in grant order.
module panda_ram_arbiter
  import panda_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Depth        = 32,
  parameter bit          RamOutputReg = 1'b1,
  localparam int unsigned AW = $clog2(Depth),
  localparam int unsigned BW = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 if_req_i,
  input  logic [AW-1:0]        if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [DataWidth-1:0] if_rdata_o,
  input  logic                 ls_req_i,
  input  logic [BW-1:0]        ls_we_i,
  input  logic [AW-1:0]        ls_addr_i,
  input  logic [DataWidth-1:0] ls_wdata_i,
  output logic                 ls_gnt_o,
  output logic                 ls_rvalid_o,
  output logic [DataWidth-1:0] ls_rdata_o,
  output logic                 ram_ce_o,
  output logic [BW-1:0]        ram_we_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  input  logic [DataWidth-1:0] ram_rdata_i
);

  localparam int unsigned Lat = RamOutputReg ? 2 : 1;

  logic [RamReqNum-1:0] req;
  logic [RamReqNum-1:0] gnt;
  ram_req_id_e          gnt_id;

  assign req = {ls_req_i, if_req_i};

  panda_rr_arbiter2 u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign if_gnt_o    = gnt[0];
  assign ls_gnt_o    = gnt[1];
  assign gnt_id      = gnt[1] ? ReqLs : ReqIf;
  assign ram_ce_o    = |gnt;
  assign ram_we_o    = gnt[1] ? ls_we_i : '0;
  assign ram_addr_o  = gnt[1] ? ls_addr_i : if_addr_i;
  assign ram_wdata_o = ls_wdata_i;

  logic [Lat-1:0]       vld_q;
  ram_req_id_e          id_q [Lat];
  logic                 sample;
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < Lat; i++) id_q[i] <= ReqIf;
    end else begin
      vld_q[0] <= ram_ce_o;
      id_q[0]  <= gnt_id;
      for (int i = 1; i < Lat; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  // Capture RAM data in the cycle it is valid at the RAM pins.
  assign sample = RamOutputReg ? vld_q[0] : ram_ce_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rdata_q <= '0;
    else if (sample) rdata_q <= ram_rdata_i;
  end

  assign if_rvalid_o = vld_q[Lat-1] && (id_q[Lat-1] == ReqIf);
  assign ls_rvalid_o = vld_q[Lat-1] && (id_q[Lat-1] == ReqLs);
  assign if_rdata_o  = rdata_q;
  assign ls_rdata_o  = rdata_q;

endmodule

// File: tb/tb_panda_ram_arbiter.sv
// Directed bench for panda_ram_arbiter, both RAM output modes.
// Each DUT drives its own behavioural RAM.
module tb_panda_ram_arbiter;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int BW  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic pre;
  always #5 clk = ~clk;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          ls_req;
  logic [BW-1:0] ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;

  logic          if_gnt1, if_rv1, ls_gnt1, ls_rv1, ce1;
  logic [DW-1:0] if_rd1, ls_rd1, wd1, rd1;
  logic [BW-1:0] we1;
  logic [AW-1:0] addr1;

  logic          if_gnt0, if_rv0, ls_gnt0, ls_rv0, ce0;
  logic [DW-1:0] if_rd0, ls_rd0, wd0, rd0;
  logic [BW-1:0] we0;
  logic [AW-1:0] addr0;

  panda_ram_arbiter #(
    .DataWidth(DW), .Depth(DEP), .RamOutputReg(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt1), .if_rvalid_o(if_rv1), .if_rdata_o(if_rd1),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt1), .ls_rvalid_o(ls_rv1), .ls_rdata_o(ls_rd1),
    .ram_ce_o(ce1), .ram_we_o(we1), .ram_addr_o(addr1),
    .ram_wdata_o(wd1), .ram_rdata_i(rd1)
  );

  panda_ram_arbiter #(
    .DataWidth(DW), .Depth(DEP), .RamOutputReg(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt0), .if_rvalid_o(if_rv0), .if_rdata_o(if_rd0),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt0), .ls_rvalid_o(ls_rv0), .ls_rdata_o(ls_rd0),
    .ram_ce_o(ce0), .ram_we_o(we0), .ram_addr_o(addr0),
    .ram_wdata_o(wd0), .ram_rdata_i(rd0)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 3) return 32'hDEADBEEF;
    if (i == 5) return 32'hAAAAAAAA;
    return 32'h1000_0000 + DW'(i);
  endfunction

  logic [DW-1:0] mem1 [DEP];
  logic [DW-1:0] mem0 [DEP];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < DEP; i++) mem1[i] <= init_word(i);
    end else if (ce1) begin
      for (int b = 0; b < BW; b++)
        if (we1[b]) mem1[addr1][8*b +: 8] <= wd1[8*b +: 8];
      rd1 <= mem1[addr1];
    end
  end

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < DEP; i++) mem0[i] <= init_word(i);
    end else if (ce0) begin
      for (int b = 0; b < BW; b++)
        if (we0[b]) mem0[addr0][8*b +: 8] <= wd0[8*b +: 8];
    end
  end
  assign rd0 = mem0[addr0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [AW-1:0] ia,
                     input logic lr, input logic [BW-1:0] lw,
                     input logic [AW-1:0] la, input logic [DW-1:0] ld);
    if_req   = ir;
    if_addr  = ia;
    ls_req   = lr;
    ls_we    = lw;
    ls_addr  = la;
    ls_wdata = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pre   = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_if_gnt", if_gnt1, 0);
    chk("rst_ls_gnt", ls_gnt1, 0);
    chk("rst_if_rv", if_rv1, 0);
    chk("rst_ls_rv", ls_rv1, 0);
    chk("rst_ce", ce1, 0);
    chk("rst_we", we1, 0);
    chk("rst_rdata", if_rd1, 0);
    tick();
    tick();
    pre = 1'b0;
    tick();
    rst_n = 1'b1;

    // fetch only, addr 3
    tick();
    drv(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("f_gnt", if_gnt1, 1);
    chk("f_ls_gnt", ls_gnt1, 0);
    chk("f_ce", ce1, 1);
    chk("f_addr", addr1, 3);
    chk("f_we", we1, 0);
    chk("f_gnt0", if_gnt0, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("f_rv_n1", if_rv1, 0);
    chk("f_ls_rv_n1", ls_rv1, 0);
    chk("f0_rv_n1", if_rv0, 1);
    chk("f0_rd_n1", if_rd0, 32'hDEADBEEF);
    chk("f0_ls_rv_n1", ls_rv0, 0);
    tick();
    @(negedge clk);
    chk("f_rv_n2", if_rv1, 1);
    chk("f_rd_n2", if_rd1, 32'hDEADBEEF);
    chk("f_ls_rv_n2", ls_rv1, 0);
    chk("f0_rv_n2", if_rv0, 0);
    tick();
    @(negedge clk);
    chk("f_rv_n3", if_rv1, 0);

    // both requesting for 6 cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6) drv(1, 3, 1, 0, 5, 0);
      else       drv(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 6) begin
        chk($sformatf("rr_ls_gnt%0d", k), ls_gnt1, (k % 2 == 0));
        chk($sformatf("rr_if_gnt%0d", k), if_gnt1, (k % 2 == 1));
        chk($sformatf("rr_ce%0d", k), ce1, 1);
      end
      if (k >= 2) begin
        chk($sformatf("rr_ls_rv%0d", k), ls_rv1, (k % 2 == 0));
        chk($sformatf("rr_if_rv%0d", k), if_rv1, (k % 2 == 1));
        chk($sformatf("rr_rd%0d", k),
            (k % 2 == 0) ? ls_rd1 : if_rd1,
            (k % 2 == 0) ? 32'hAAAAAAAA : 32'hDEADBEEF);
      end
    end

    // byte write then load, addr 5
    tick();
    drv(0, 0, 1, 4'b0101, 5, 32'h11223344);
    @(negedge clk);
    chk("bw_gnt", ls_gnt1, 1);
    chk("bw_we", we1, 4'b0101);
    chk("bw_wd", wd1, 32'h11223344);
    tick();
    drv(0, 0, 1, 4'b0000, 5, 0);
    @(negedge clk);
    chk("ld_gnt", ls_gnt1, 1);
    chk("ld_we", we1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bw_rv", ls_rv1, 1);
    chk("bw_if_rv", if_rv1, 0);
    tick();
    @(negedge clk);
    chk("ld_rv", ls_rv1, 1);
    chk("ld_rd", ls_rd1, 32'hAA22AA44);

    // store then fetch of addr 7
    tick();
    drv(0, 0, 1, 4'b1111, 7, 32'hCAFEF00D);
    @(negedge clk);
    chk("st_gnt", ls_gnt1, 1);
    tick();
    drv(1, 7, 0, 0, 0, 0);
    @(negedge clk);
    chk("sf_gnt", if_gnt1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("st_rv", ls_rv1, 1);
    chk("st_if_rv", if_rv1, 0);
    tick();
    @(negedge clk);
    chk("sf_rv", if_rv1, 1);
    chk("sf_rd", if_rd1, 32'hCAFEF00D);
    chk("sf_ls_rv", ls_rv1, 0);

    // reset one cycle after a grant
    tick();
    drv(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("rg_gnt", if_gnt1, 1);
    tick();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rh_if_rv%0d", k), if_rv1, 0);
      chk($sformatf("rh_ls_rv%0d", k), ls_rv1, 0);
      chk($sformatf("rh_if_gnt%0d", k), if_gnt1, 0);
      chk($sformatf("rh_ce%0d", k), ce1, 0);
      chk($sformatf("rh_rd%0d", k), if_rd1, 0);
      chk($sformatf("rh0_rv%0d", k), if_rv0, 0);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ra_gnt", if_gnt1, 1);
    chk("ra_ce", ce1, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ra_rv_n1", if_rv1, 0);
    tick();
    @(negedge clk);
    chk("ra_rv_n2", if_rv1, 1);
    chk("ra_rd_n2", if_rd1, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panda_ram_arbiter.md
Name: panda_ram_arbiter

Overview:
Shares one single-port panda_ram instance between two requesters: instruction fetch (port 0, read-only) and load/store (port 1, read/write with byte enables).
- Grants at most one request per cycle using two-way round-robin.
- Drives the RAM enable, write-enable, address and write-data pins.
- Tracks in-flight accesses so that each response returns to the requester that issued it.
- Sits between the core's fetch/LSU interfaces and the on-chip RAM.

Parameters:
- DataWidth, 32, data width; must be a multiple of 8 and must match the RAM instance.
- Depth, 32, RAM word count; address width is $clog2(Depth).
- RamOutputReg, 1'b1, must equal the RAM's OutputReg; RAM read latency is 1 when set, 0 when clear.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  AW  fetch word address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DataWidth  fetch read data
- ls_req_i  in  1  load/store request
- ls_we_i  in  DataWidth/8  byte write enables; all zero means read
- ls_addr_i  in  AW  load/store word address
- ls_wdata_i  in  DataWidth  store data
- ls_gnt_o  out  1  load/store request accepted
- ls_rvalid_o  out  1  load/store response; issued for reads and writes
- ls_rdata_o  out  DataWidth  load data; undefined on write responses
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  DataWidth/8  RAM byte write enables
- ram_addr_o  out  AW  RAM address
- ram_wdata_o  out  DataWidth  RAM write data
- ram_rdata_i  in  DataWidth  RAM read data

Behaviour:
- Reset: all gnt/rvalid outputs 0, ram_ce_o 0, ram_we_o 0, rdata outputs 0, response pipeline cleared. The round-robin pointer resets to favour load/store (last_grant = fetch).
- Grant logic is combinational within the cycle.
  - Only one request pending: that request is granted.
  - Both pending: grant the port not granted last, then flip last_grant.
  - last_grant updates only on an actual grant.
- A requester holds req, addr and data stable until gnt. Dropping req before gnt is permitted; nothing is issued.
- On the grant cycle:
  - ram_ce_o = 1.
  - ram_addr_o and ram_wdata_o come from the granted port.
  - ram_we_o = ls_we_i when load/store is granted, otherwise 0.
- With no grant: ram_ce_o = 0 and ram_we_o = 0. ram_addr_o and ram_wdata_o are don't-care.
- Response pipeline: a shift register of {valid, id}, depth L = 1 + RamOutputReg.
  - Stage 0 is loaded on the grant cycle.
  - The arbiter registers ram_rdata_i into a response register at the stage where RAM data is valid:
    - RamOutputReg=0: sampled in the grant cycle.
    - RamOutputReg=1: sampled one cycle after the grant.
- Latency: a request granted in cycle N has rvalid (and rdata) asserted in cycle N+L, for exactly one cycle, to the owning port only.
  - The other port's rvalid is 0.
  - Both rdata outputs carry the same registered word; consumers qualify with rvalid.
- Back-to-back grants: one grant per cycle is sustained with no bubbles. Responses return in grant order.
- Read-after-write to the same address through the load/store port returns the written data, because the RAM is serial.
- Responses have no backpressure; requesters must always accept rvalid.
- Reset asserted mid-operation: in-flight responses are discarded and no rvalid is produced after reset. A write whose grant cycle completed before reset is committed to the RAM.
- Address out of range cannot occur, because the address width is $clog2(Depth).

Decomposition:
- panda_pkg gains `typedef enum logic {ReqIf, ReqLs} ram_req_id_e` and the constant RamReqNum = 2.
- Sub-module panda_rr_arbiter2: two-way round-robin, with inputs req[1:0] and outputs gnt[1:0] and a registered last-grant bit.
- Response pipeline and muxing stay in the top module.

Test Plan:
- Fetch only: if_req_i=1 with addr 3, RAM preloaded with 0xDEADBEEF at addr 3, RamOutputReg=1 -> if_gnt_o in cycle N, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF in N+2, ls_rvalid_o=0 throughout.
- Both request continuously for 6 cycles after reset -> grants alternate ls, if, ls, if, ls, if; no idle cycles on ram_ce_o; rvalid sequence matches the grant order, offset by L.
- Byte write: ls_we_i=4'b0101, wdata 0x11223344 to addr 5, which holds 0xAAAAAAAA; then a load from addr 5 -> ls_rvalid_o for the write, then load data 0xAA22AA44.
- Store then immediate fetch of the same address in consecutive cycles -> the fetch returns the new data, and responses are ordered store then fetch.
- RamOutputReg=0 build -> the same stimulus as the fetch-only scenario yields if_rvalid_o in N+1.
- rst_ni pulled low one cycle after a grant -> no rvalid ever appears for that request; all outputs are 0 while reset is held; the first request after reset is granted normally.
